// File: rtl/core_mem_responder.sv
// Core memory responder: boot-loaded instruction memory with a one-cycle fetch
// pipe, plus a data memory with combinational read and synchronous write.
module core_mem_responder #(
   parameter int unsigned IMEM_WORDS = 1024,
   parameter int unsigned DMEM_WORDS = 1024,
   parameter bit          BOOT_EN    = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] imem_request_pc_i,
   output logic [31:0] imem_response_pc_o,
   output logic [31:0] imem_response_instr_o,
   input  logic        dmem_wen_i,
   input  logic [31:0] dmem_addr_i,
   input  logic [31:0] dmem_wdata_i,
   output logic [31:0] dmem_rdata_o,
   input  logic        load_valid_i,
   input  logic [7:0]  load_byte_i,
   input  logic        load_last_i,
   output logic        boot_busy_o,
   output logic        load_err_o
);

   localparam logic [31:0] Nop    = 32'h00000013;
   localparam logic        StBoot = 1'b0;
   localparam logic        StRun  = 1'b1;
   localparam int unsigned IAW    = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
   localparam int unsigned DAW    = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

   logic [31:0] imem [IMEM_WORDS];
   logic [31:0] dmem [DMEM_WORDS];

   logic        state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] asm_q, asm_d;
   logic [31:0] word_cnt_q, word_cnt_d;
   logic        load_err_q, load_err_d;
   logic [31:0] resp_pc_q;
   logic [31:0] resp_instr_q;

   logic        boot_byte;
   logic        word_wr;
   logic        word_fits;
   logic        imem_we;
   logic [31:0] asm_word;
   logic [29:0] iidx;
   logic [29:0] didx;
   logic        ifits;
   logic        dfits;
   logic        dmem_we;
   logic [31:0] lookup;
   logic        unused_addr_lsbs;

   assign boot_byte = (state_q == StBoot) && load_valid_i;
   assign word_wr   = boot_byte && ((byte_cnt_q == 2'd3) || load_last_i);
   assign word_fits = word_cnt_q < IMEM_WORDS;
   // Gated by reset so a partial word is never committed while reset is held.
   assign imem_we   = word_wr && word_fits && !rst_i;

   assign iidx  = imem_request_pc_i[31:2];
   assign didx  = dmem_addr_i[31:2];
   assign ifits = {2'b00, iidx} < IMEM_WORDS;
   assign dfits = {2'b00, didx} < DMEM_WORDS;
   assign dmem_we = dmem_wen_i && (state_q == StRun) && dfits && !rst_i;

   assign unused_addr_lsbs = ^{imem_request_pc_i[1:0], dmem_addr_i[1:0]};

   // Merge the incoming boot byte into its lane of the assembly register.
   always_comb begin
      asm_word = asm_q;
      asm_word[{byte_cnt_q, 3'b000} +: 8] = load_byte_i;
   end

   // Boot loader next state: byte lanes, word counter, overflow flag, FSM.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      word_cnt_d = word_cnt_q;
      load_err_d = load_err_q;
      if (boot_byte) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         // Clear after a commit so unfilled lanes of the next word read as zero.
         asm_d = word_wr ? 32'd0 : asm_word;
         if (word_wr) begin
            if (word_fits) begin
               word_cnt_d = word_cnt_q + 32'd1;
            end else begin
               load_err_d = 1'b1;
            end
         end
         if (load_last_i) begin
            state_d = StRun;
         end
      end
   end

   // Instruction lookup; NOP while booting or beyond the loaded memory.
   always_comb begin
      lookup = Nop;
      if ((state_q == StRun) && ifits) begin
         lookup = imem[iidx[IAW-1:0]];
      end
   end

   // Combinational data read; out-of-range words read as zero.
   always_comb begin
      dmem_rdata_o = 32'd0;
      if (dfits) begin
         dmem_rdata_o = dmem[didx[DAW-1:0]];
      end
   end

   // Control state and fetch response pipe.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= BOOT_EN ? StBoot : StRun;
         byte_cnt_q   <= 2'd0;
         asm_q        <= 32'd0;
         word_cnt_q   <= 32'd0;
         load_err_q   <= 1'b0;
         resp_pc_q    <= 32'd0;
         resp_instr_q <= Nop;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         asm_q        <= asm_d;
         word_cnt_q   <= word_cnt_d;
         load_err_q   <= load_err_d;
         resp_pc_q    <= imem_request_pc_i;
         resp_instr_q <= lookup;
      end
   end

   // Instruction memory write port; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (imem_we) begin
         imem[word_cnt_q[IAW-1:0]] <= asm_word;
      end
   end

   // Data memory write port; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (dmem_we) begin
         dmem[didx[DAW-1:0]] <= dmem_wdata_i;
      end
   end

   assign imem_response_pc_o    = resp_pc_q;
   assign imem_response_instr_o = resp_instr_q;
   assign boot_busy_o           = (state_q == StBoot);
   assign load_err_o            = load_err_q;

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: three instances share stimulus (default size,
// IMEM_WORDS=2, BOOT_EN=0) and are compared against a byte-queue memory model.
module tb_core_mem_responder;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst, lvalid, llast, wen;
   logic [7:0]  lbyte;
   logic [31:0] req_pc, daddr, wdata;
   logic [31:0] rpc [3];
   logic [31:0] rins [3];
   logic [31:0] rdat [3];
   logic        busy [3];
   logic        lerr [3];

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   bit          m_boot [3];
   int unsigned m_wc [3];
   bit          m_err [3];
   logic [7:0]  bq [$];
   logic [31:0] im_e [3][16];
   bit          im_v [3][16];
   logic [31:0] dm_e [3][128];
   bit          dm_v [3][128];
   logic [31:0] e_pc [3];
   logic [31:0] e_ins [3];
   bit          e_ins_v [3];

   always #5 clk = ~clk;

   core_mem_responder #(.IMEM_WORDS(1024), .DMEM_WORDS(1024), .BOOT_EN(1'b1)) u_main (
      .clk_i(clk), .rst_i(rst), .imem_request_pc_i(req_pc),
      .imem_response_pc_o(rpc[0]), .imem_response_instr_o(rins[0]),
      .dmem_wen_i(wen), .dmem_addr_i(daddr), .dmem_wdata_i(wdata), .dmem_rdata_o(rdat[0]),
      .load_valid_i(lvalid), .load_byte_i(lbyte), .load_last_i(llast),
      .boot_busy_o(busy[0]), .load_err_o(lerr[0]));

   core_mem_responder #(.IMEM_WORDS(2), .DMEM_WORDS(16), .BOOT_EN(1'b1)) u_small (
      .clk_i(clk), .rst_i(rst), .imem_request_pc_i(req_pc),
      .imem_response_pc_o(rpc[1]), .imem_response_instr_o(rins[1]),
      .dmem_wen_i(wen), .dmem_addr_i(daddr), .dmem_wdata_i(wdata), .dmem_rdata_o(rdat[1]),
      .load_valid_i(lvalid), .load_byte_i(lbyte), .load_last_i(llast),
      .boot_busy_o(busy[1]), .load_err_o(lerr[1]));

   core_mem_responder #(.IMEM_WORDS(4), .DMEM_WORDS(4), .BOOT_EN(1'b0)) u_run (
      .clk_i(clk), .rst_i(rst), .imem_request_pc_i(req_pc),
      .imem_response_pc_o(rpc[2]), .imem_response_instr_o(rins[2]),
      .dmem_wen_i(wen), .dmem_addr_i(daddr), .dmem_wdata_i(wdata), .dmem_rdata_o(rdat[2]),
      .load_valid_i(lvalid), .load_byte_i(lbyte), .load_last_i(llast),
      .boot_busy_o(busy[2]), .load_err_o(lerr[2]));

   function automatic int unsigned iw(input int i);
      case (i)
         0: return 1024;
         1: return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int unsigned dw(input int i);
      case (i)
         0: return 1024;
         1: return 16;
         default: return 4;
      endcase
   endfunction

   function automatic bit be(input int i);
      return (i != 2);
   endfunction

   // Little-endian word from the pending bytes, missing lanes zero.
   function automatic logic [31:0] pack_bytes();
      logic [31:0] w;
      w = 32'd0;
      for (int j = 0; j < bq.size(); j++) w = w | (32'(bq[j]) << (8 * j));
      return w;
   endfunction

   function automatic void rd_exp(input int i, input logic [31:0] a,
                                  output logic [31:0] v, output bit known);
      int unsigned idx;
      idx = a >> 2;
      v = 32'd0;
      known = 1'b0;
      if (idx >= dw(i)) known = 1'b1;
      else if (idx < 128 && dm_v[i][idx]) begin
         v = dm_e[i][idx];
         known = 1'b1;
      end
   endfunction

   // One clock edge: update the model from current inputs, then advance.
   task automatic tick();
      bit full;
      full = 1'b0;
      for (int i = 0; i < 3; i++) begin
         int unsigned idx;
         idx = req_pc >> 2;
         e_pc[i] = rst ? 32'd0 : req_pc;
         e_ins_v[i] = 1'b1;
         if (rst || m_boot[i] || idx >= iw(i)) e_ins[i] = NOP;
         else if (idx < 16 && im_v[i][idx]) e_ins[i] = im_e[i][idx];
         else begin
            e_ins[i] = 32'd0;
            e_ins_v[i] = 1'b0;
         end
      end
      // Both boot-enabled instances see identical inputs, so they share one queue.
      if (!rst && lvalid && m_boot[0]) begin
         bq.push_back(lbyte);
         full = (bq.size() == 4) || llast;
      end
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_boot[i] = be(i);
            m_wc[i] = 0;
            m_err[i] = 1'b0;
         end else if (m_boot[i]) begin
            if (full) begin
               if (m_wc[i] < iw(i)) begin
                  if (m_wc[i] < 16) begin
                     im_e[i][m_wc[i]] = pack_bytes();
                     im_v[i][m_wc[i]] = 1'b1;
                  end
                  m_wc[i]++;
               end else m_err[i] = 1'b1;
            end
            if (lvalid && llast) m_boot[i] = 1'b0;
         end else if (wen) begin
            int unsigned didx;
            didx = daddr >> 2;
            if (didx < dw(i) && didx < 128) begin
               dm_e[i][didx] = wdata;
               dm_v[i][didx] = 1'b1;
            end
         end
      end
      if (rst || full) bq.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; lvalid = 1'b0; llast = 1'b0; lbyte = 8'd0; wen = 1'b0;
      req_pc = 32'h0000_0040; daddr = 32'd0; wdata = 32'd0;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         vectors += 4;
         if (rpc[i] !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_pc inst%0d: got %h want 00000000", i, rpc[i]);
         end
         if (rins[i] !== NOP) begin
            miscompares++;
            $display("FAIL reset_instr inst%0d: got %h want %h", i, rins[i], NOP);
         end
         if (busy[i] !== be(i)) begin
            miscompares++;
            $display("FAIL reset_busy inst%0d: got %b want %b", i, busy[i], be(i));
         end
         if (lerr[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err inst%0d: got %b want 0", i, lerr[i]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_boot_image();
      logic [7:0] img [8];
      img = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int k = 0; k < 8; k++) begin
         lvalid = 1'b1; lbyte = img[k]; llast = (k == 7); req_pc = $urandom;
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (busy[i] !== 1'b1) begin
               miscompares++;
               $display("FAIL boot_busy_before inst%0d byte%0d: got %b want 1", i, k, busy[i]);
            end
         end
         tick();
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rpc[i] !== e_pc[i]) begin
               miscompares++;
               $display("FAIL boot_fetch_pc inst%0d: got %h want %h", i, rpc[i], e_pc[i]);
            end
            if (e_ins_v[i]) begin
               vectors++;
               if (rins[i] !== e_ins[i]) begin
                  miscompares++;
                  $display("FAIL boot_fetch_instr inst%0d: got %h want %h", i, rins[i], e_ins[i]);
               end
            end
         end
      end
      lvalid = 1'b0; llast = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors += 2;
         if (busy[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_busy_after inst%0d: got %b want 0", i, busy[i]);
         end
         if (lerr[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_err inst%0d: got %b want 0", i, lerr[i]);
         end
      end
   endtask

   task automatic test_fetch();
      logic [31:0] pcs [5];
      logic [31:0] exp_w [5];
      pcs   = '{32'h4, 32'h6, 32'h0, 32'h3, 32'h1000};
      exp_w = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h00100513, 32'h00100513, NOP};
      for (int k = 0; k < 5; k++) begin
         req_pc = pcs[k];
         tick();
         for (int i = 0; i < 2; i++) begin
            vectors += 2;
            if (rpc[i] !== pcs[k]) begin
               miscompares++;
               $display("FAIL fetch_pc inst%0d pc=%h: got %h", i, pcs[k], rpc[i]);
            end
            if (rins[i] !== exp_w[k]) begin
               miscompares++;
               $display("FAIL fetch_instr inst%0d pc=%h: got %h want %h", i, pcs[k], rins[i],
                        exp_w[k]);
            end
         end
      end
      for (int k = 0; k < 40; k++) begin
         req_pc = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 23);
         lvalid = $urandom_range(0, 1); lbyte = 8'($urandom); llast = $urandom_range(0, 1);
         tick();
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rpc[i] !== e_pc[i]) begin
               miscompares++;
               $display("FAIL rand_fetch_pc inst%0d: got %h want %h", i, rpc[i], e_pc[i]);
            end
            if (e_ins_v[i]) begin
               vectors++;
               if (rins[i] !== e_ins[i]) begin
                  miscompares++;
                  $display("FAIL rand_fetch_instr inst%0d pc=%h: got %h want %h", i, e_pc[i],
                           rins[i], e_ins[i]);
               end
            end
         end
      end
      lvalid = 1'b0; llast = 1'b0;
   endtask

   task automatic test_dmem();
      logic [31:0] old_w, v;
      bit known;
      old_w = $urandom;
      wen = 1'b1; daddr = 32'h100; wdata = old_w;
      tick();
      wdata = 32'h12345678;
      #1;
      vectors++;
      if (rdat[0] !== old_w) begin
         miscompares++;
         $display("FAIL dmem_same_cycle_old: got %h want %h", rdat[0], old_w);
      end
      tick();
      wen = 1'b0;
      #1;
      vectors++;
      if (rdat[0] !== 32'h12345678) begin
         miscompares++;
         $display("FAIL dmem_next_cycle_new: got %h want 12345678", rdat[0]);
      end
      wen = 1'b1; daddr = 32'h1000; wdata = 32'hCAFEF00D;
      tick();
      wen = 1'b0;
      #1;
      vectors++;
      if (rdat[0] !== 32'd0) begin
         miscompares++;
         $display("FAIL dmem_out_of_range: got %h want 00000000", rdat[0]);
      end
      for (int k = 0; k < 60; k++) begin
         wen = $urandom_range(0, 1);
         daddr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 159));
         wdata = $urandom;
         #1;
         for (int i = 0; i < 3; i++) begin
            rd_exp(i, daddr, v, known);
            if (known) begin
               vectors++;
               if (rdat[i] !== v) begin
                  miscompares++;
                  $display("FAIL rand_dmem inst%0d addr=%h: got %h want %h", i, daddr, rdat[i], v);
               end
            end
         end
         tick();
      end
      wen = 1'b0;
   endtask

   task automatic test_overflow();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         lvalid = 1'b1; lbyte = 8'($urandom); llast = (k == 11); req_pc = $urandom;
         tick();
      end
      lvalid = 1'b0; llast = 1'b0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (lerr[i] !== m_err[i]) begin
               miscompares++;
               $display("FAIL overflow_err inst%0d cyc%0d: got %b want %b", i, c, lerr[i], m_err[i]);
            end
         end
         vectors++;
         if (lerr[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_err_small cyc%0d: got %b want 1", c, lerr[1]);
         end
         req_pc = 32'(4 * c);
         tick();
         for (int i = 0; i < 3; i++) begin
            if (e_ins_v[i]) begin
               vectors++;
               if (rins[i] !== e_ins[i]) begin
                  miscompares++;
                  $display("FAIL overflow_fetch inst%0d pc=%h: got %h want %h", i, req_pc, rins[i],
                           e_ins[i]);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid_boot();
      logic [31:0] k_w, v;
      bit known;
      k_w = $urandom;
      wen = 1'b1; daddr = 32'h20; wdata = k_w;
      tick();
      wen = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         lvalid = 1'b1; lbyte = 8'($urandom); llast = 1'b0;
         wen = 1'b1; daddr = 32'h20; wdata = ~k_w;
         tick();
      end
      lvalid = 1'b0; rst = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         vectors += 2;
         if (busy[i] !== be(i)) begin
            miscompares++;
            $display("FAIL midboot_busy inst%0d: got %b want %b", i, busy[i], be(i));
         end
         if (lerr[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL midboot_err inst%0d: got %b want 0", i, lerr[i]);
         end
      end
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         lvalid = 1'b1; lbyte = 8'($urandom); llast = (k == 3);
         tick();
      end
      lvalid = 1'b0; llast = 1'b0; wen = 1'b0; daddr = 32'h20;
      #1;
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (rdat[i] !== k_w) begin
            miscompares++;
            $display("FAIL boot_dmem_guard inst%0d: got %h want %h", i, rdat[i], k_w);
         end
      end
      rd_exp(2, daddr, v, known);
      if (known) begin
         vectors++;
         if (rdat[2] !== v) begin
            miscompares++;
            $display("FAIL boot_dmem_run_inst: got %h want %h", rdat[2], v);
         end
      end
      req_pc = 32'h0;
      tick();
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (rins[i] !== e_ins[i]) begin
            miscompares++;
            $display("FAIL reload_word0 inst%0d: got %h want %h", i, rins[i], e_ins[i]);
         end
      end
   endtask

   task automatic test_partial();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      lvalid = 1'b1; lbyte = 8'hAA; llast = 1'b0;
      tick();
      lbyte = 8'hBB; llast = 1'b1;
      tick();
      lvalid = 1'b0; llast = 1'b0;
      req_pc = 32'h0;
      tick();
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (rins[i] !== 32'h0000BBAA) begin
            miscompares++;
            $display("FAIL partial_word inst%0d: got %h want 0000BBAA", i, rins[i]);
         end
      end
      req_pc = 32'h4;
      tick();
      for (int i = 0; i < 3; i++) begin
         if (e_ins_v[i]) begin
            vectors++;
            if (rins[i] !== e_ins[i]) begin
               miscompares++;
               $display("FAIL retained_word1 inst%0d: got %h want %h", i, rins[i], e_ins[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_boot_image();
      test_fetch();
      test_dmem();
      test_overflow();
      test_reset_mid_boot();
      test_partial();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/core_mem_responder.md
CORE_MEM_RESPONDER -- requirements
Module: core_mem_responder

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 1024, instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 1024, data memory depth in 32-bit words.
REQ-003 SHALL have parameter BOOT_EN, default 1, 1 = enter BOOT after reset, 0 = enter RUN directly.
REQ-004 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  in  1  asynchronous active-high reset.
REQ-006 SHALL have port imem_request_pc_i  in  32  fetch address from core.
REQ-007 SHALL have port imem_response_pc_o  out  32  PC that the returned instruction belongs to.
REQ-008 SHALL have port imem_response_instr_o  out  32  instruction word for imem_response_pc_o.
REQ-009 SHALL have port dmem_wen_i  in  1  data write enable.
REQ-010 SHALL have port dmem_addr_i  in  32  data byte address.
REQ-011 SHALL have port dmem_wdata_i  in  32  data write word.
REQ-012 SHALL have port dmem_rdata_o  out  32  data read word.
REQ-013 SHALL have port load_valid_i  in  1  boot byte valid.
REQ-014 SHALL have port load_byte_i  in  8  boot byte, program image in little-endian order.
REQ-015 SHALL have port load_last_i  in  1  qualifies final byte of image, sampled only with load_valid_i.
REQ-016 SHALL have port boot_busy_o  out  1  high while in BOOT.
REQ-017 SHALL have port load_err_o  out  1  sticky, image overflowed IMEM_WORDS.

Function
REQ-018 SHALL implement FSM with states BOOT and RUN; reset enters BOOT if BOOT_EN=1, else RUN.
REQ-019 BOOT->RUN SHALL occur on the clock edge where load_valid_i=1 and load_last_i=1; RUN has no exit except reset.
REQ-020 In BOOT, each valid byte SHALL be placed into byte lane byte_cnt (0..3) of an assembly register; byte_cnt increments mod 4.
REQ-021 When byte_cnt=3 with a valid byte, or on the last byte, the assembled word SHALL be written to imem[word_cnt] in the same edge, unfilled lanes zero; word_cnt then increments.
REQ-022 Word writes with word_cnt >= IMEM_WORDS SHALL be discarded and set load_err_o=1; word_cnt saturates at IMEM_WORDS.
REQ-023 Fetch SHALL have latency 1: on each edge imem_response_pc_o <= imem_request_pc_i and imem_response_instr_o <= lookup, every cycle, no handshake.
REQ-024 Lookup SHALL be imem[pc[31:2]]; pc[1:0] ignored; index >= IMEM_WORDS returns 32'h00000013.
REQ-025 In BOOT, lookup SHALL return 32'h00000013 (NOP) regardless of address; response PC still tracks request.
REQ-026 Data read SHALL be combinational: dmem_rdata_o = dmem[dmem_addr_i[31:2]]; index >= DMEM_WORDS returns 0.
REQ-027 Data write SHALL occur on the rising edge when dmem_wen_i=1, in RUN, and index < DMEM_WORDS; writes otherwise ignored.
REQ-028 Read of the address being written in the same cycle SHALL return the old word; new word visible next cycle.
REQ-029 dmem_addr_i[1:0] SHALL be ignored; full 32-bit word writes only.
REQ-030 load_valid_i in RUN SHALL be ignored.

Reset
REQ-031 On rst_i: imem_response_pc_o=0, imem_response_instr_o=32'h00000013, byte_cnt=0, word_cnt=0, assembly register=0, load_err_o=0, boot_busy_o=BOOT_EN.
REQ-032 Memory arrays SHALL NOT be cleared by reset; contents hold until overwritten.
REQ-033 Reset asserted mid-boot SHALL abandon the partial word (not written) and restart loading at word 0.

Verification
REQ-034 Boot bytes 13,05,10,00 then EF,BE,AD,DE (last) -> imem[0]=0x00100513, imem[1]=0xDEADBEEF, boot_busy_o falls after last byte edge.
REQ-035 In RUN, request pc 0x4 at cycle n -> cycle n+1 response_pc=0x4, instr=0xDEADBEEF; request 0x6 -> same word; pc 4*IMEM_WORDS -> 0x00000013.
REQ-036 Partial last word: bytes AA, BB(last) -> imem[0]=0x0000BBAA.
REQ-037 Write 0x12345678 to 0x100 while reading 0x100 -> rdata old value that cycle, 0x12345678 next; write to 4*DMEM_WORDS ignored, read returns 0.
REQ-038 With IMEM_WORDS=2, load 12 bytes -> words 0,1 written, third discarded, load_err_o=1 until reset.
REQ-039 Assert rst_i after 6 bytes of boot -> boot_busy_o=1, load_err_o=0; reload 4 bytes lands at imem[0]; dmem_wen_i during BOOT leaves dmem unchanged.
